// File: rtl/led_pkg.sv
// Shared types and constants for the LED count controller.
package led_pkg;

    localparam int unsigned CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // Pattern the downstream LED stage shows straight out of reset
    localparam cnt_t DISP_RST = 8'h00;

    function automatic cnt_t step_cnt(input cnt_t c, input logic up);
        return up ? c + cnt_t'(1) : c - cnt_t'(1);
    endfunction

    function automatic logic is_wrap(input cnt_t c, input logic up);
        return up ? (c == '1) : (c == '0);
    endfunction

endpackage

// File: rtl/led_count_ctrl_if.sv
// Command and status bundle between the button front-end and the count controller.
interface led_count_ctrl_if;

    logic                       start;
    logic                       stop;
    logic                       load_en;
    logic [led_pkg::CNT_W-1:0]  load_val;
    logic                       dir;
    logic [led_pkg::CNT_W-1:0]  cnt_data;
    logic [1:0]                 state;
    logic                       tick;
    logic                       wrap;

    modport master (
        output start, stop, load_en, load_val, dir,
        input  cnt_data, state, tick, wrap
    );

    modport slave (
        input  start, stop, load_en, load_val, dir,
        output cnt_data, state, tick, wrap
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 divider; tick_c flags the terminal count while enabled.
module tick_prescaler #(
    parameter int unsigned DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // A clear cancels the step that would otherwise fall on this edge
    assign tick_c = en && !clr && (pre_q == TERM);

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == TERM) ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/led_count_ctrl.sv
// Run/pause/idle sequencer stepping the 8-bit LED count on each prescaled tick.
module led_count_ctrl
    import led_pkg::*;
#(
    parameter int unsigned DIV     = 50000000,
    parameter int unsigned WIDTH   = 8,
    parameter cnt_t        CLR_VAL = DISP_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    led_count_ctrl_if.slave  bus
);

    state_e           st_q;
    state_e           st_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             clear_c;
    logic             pre_en_c;
    logic             pre_clr_c;
    logic             step_c;

    // Second stop while paused returns to idle and wipes the count
    assign clear_c   = (st_q == ST_PAUSE) && bus.stop;
    assign pre_en_c  = (st_q == ST_RUN);
    assign pre_clr_c = (st_q == ST_IDLE) || bus.load_en || clear_c;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pre_en_c),
        .clr    (pre_clr_c),
        .tick_c (step_c)
    );

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;

        // stop has priority over start in every state
        case (st_q)
            ST_IDLE:  if (bus.start && !bus.stop) st_d = ST_RUN;
            ST_RUN:   if (bus.stop) st_d = ST_PAUSE;
            ST_PAUSE: begin
                if (bus.stop) begin
                    st_d = ST_IDLE;
                end else if (bus.start) begin
                    st_d = ST_RUN;
                end
            end
            default:  st_d = ST_IDLE;
        endcase

        if (clear_c) begin
            cnt_d = CLR_VAL;
        end else if (bus.load_en) begin
            cnt_d = bus.load_val;
        end else if (step_c) begin
            cnt_d  = step_cnt(cnt_q, bus.dir);
            tick_d = 1'b1;
            wrap_d = is_wrap(cnt_q, bus.dir);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            cnt_q  <= CLR_VAL;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.cnt_data = cnt_q;
    assign bus.state    = st_q;
    assign bus.tick     = tick_q;
    assign bus.wrap     = wrap_q;

endmodule
